reg_file_cmd_ctrl: RTL and testbench
====================================

REG_FILE_CMD_CTRL -- requirements
Module: reg_file_cmd_ctrl

Interface
REQ-001 Parameter DATA_WIDTH, 16, register-file word width.
REQ-002 Parameter ADDR_WIDTH, 4, register-file address width.
REQ-003 Parameter RF_DEPTH, 8, number of implemented register-file entries.
REQ-004 CLK  input  1  single system clock; all logic rising-edge.
REQ-005 RST  input  1  asynchronous, active-low reset.
REQ-006 RX_P_DATA  input  8  received command/operand byte.
REQ-007 RX_D_VLD  input  1  one-cycle pulse; RX_P_DATA valid this cycle.
REQ-008 Address  output  ADDR_WIDTH  register-file address.
REQ-009 WrEn  output  1  register-file write strobe.
REQ-010 WrData  output  DATA_WIDTH  register-file write data.
REQ-011 RdEn  output  1  register-file read strobe.
REQ-012 RdData  input  DATA_WIDTH  register-file read data, valid the cycle after RdEn.
REQ-013 TX_P_DATA  output  8  byte to transmitter.
REQ-014 TX_D_VLD  output  1  TX_P_DATA valid; held until accepted.
REQ-015 TX_BUSY  input  1  transmitter busy; byte accepted on an edge with TX_D_VLD=1 and TX_BUSY=0.
REQ-016 CMD_ERR  output  1  one-cycle error pulse.

Function
REQ-017 Write frame SHALL be 0xAA, addr, data_lo, data_hi; read frame SHALL be 0xBB, addr.
REQ-018 FSM states SHALL be IDLE, WR_ADDR, WR_LO, WR_HI, WR_EXEC, RD_ADDR, RD_REQ, RD_CAP, TX_LO, TX_HI.
REQ-019 IDLE: RX byte 0xAA -> WR_ADDR; 0xBB -> RD_ADDR; any other byte -> CMD_ERR pulse, stay IDLE.
REQ-020 WR_ADDR/RD_ADDR: byte < RF_DEPTH latched into Address, advance to WR_LO/RD_REQ; byte >= RF_DEPTH -> CMD_ERR pulse, IDLE, no RF access.
REQ-021 WR_LO latches WrData[7:0]; WR_HI latches WrData[15:8] and advances to WR_EXEC.
REQ-022 WR_EXEC: WrEn=1 for exactly one cycle (cycle after data_hi accepted), then IDLE.
REQ-023 RD_REQ: RdEn=1 for exactly one cycle; RD_CAP captures RdData into internal 16-bit buffer.
REQ-024 TX_LO drives buffer[7:0], TX_HI drives buffer[15:8], each with TX_D_VLD=1 until accepted; after high byte accepted -> IDLE, TX_D_VLD=0.
REQ-025 WrEn and RdEn SHALL never be high in the same cycle.
REQ-026 RX_D_VLD in RD_REQ, RD_CAP, TX_LO, TX_HI or WR_EXEC: byte dropped, CMD_ERR pulse, state unaffected.
REQ-027 Without RX_D_VLD, all waiting states hold indefinitely; no timeout.
REQ-028 TX_BUSY held high SHALL stall TX_LO/TX_HI with TX_P_DATA stable.
REQ-029 All outputs SHALL be registered.

Reset
REQ-030 RST low SHALL immediately force IDLE and Address=0, WrData=0, WrEn=0, RdEn=0, TX_P_DATA=0, TX_D_VLD=0, CMD_ERR=0, buffer=0.
REQ-031 Reset mid-frame SHALL discard the partial frame; the next byte after release is parsed as a command.

Structure
REQ-032 Package reg_file_cmd_pkg SHALL hold state encoding, CMD_WR=0xAA, CMD_RD=0xBB and RF_DEPTH default.
REQ-033 Single module, one FSM plus datapath registers; no sub-module.

Verification
REQ-034 Send AA,03,34,12 -> one cycle later WrEn=1, Address=3, WrData=0x1234, one cycle only.
REQ-035 Send BB,03 with RF model holding 0x1234, TX_BUSY=0 -> RdEn one cycle, then TX bytes 0x34 then 0x12, then IDLE.
REQ-036 Send 0x55 in IDLE -> CMD_ERR one cycle, no WrEn/RdEn; send AA,09 -> CMD_ERR, no write.
REQ-037 Read with TX_BUSY high 20 cycles -> TX_D_VLD held, TX_P_DATA=0x34 stable, released when TX_BUSY low.
REQ-038 Assert RST after AA,03,34 -> outputs zero at once; then AA,02,CD,AB -> WrEn with Address=2, WrData=0xABCD.
REQ-039 RX byte during TX_HI stall -> CMD_ERR pulse, transmitted bytes unchanged.

Source files
------------

// File: rtl/reg_file_cmd_pkg.sv
// Shared constants for the byte-stream register-file command controller:
// command opcodes, default depth and FSM state encoding.
package reg_file_cmd_pkg;

  localparam logic [7:0] CMD_WR = 8'hAA;
  localparam logic [7:0] CMD_RD = 8'hBB;

  localparam int RF_DEPTH_DEF = 8;

  localparam logic [3:0] IDLE    = 4'd0;
  localparam logic [3:0] WR_ADDR = 4'd1;
  localparam logic [3:0] WR_LO   = 4'd2;
  localparam logic [3:0] WR_HI   = 4'd3;
  localparam logic [3:0] WR_EXEC = 4'd4;
  localparam logic [3:0] RD_ADDR = 4'd5;
  localparam logic [3:0] RD_REQ  = 4'd6;
  localparam logic [3:0] RD_CAP  = 4'd7;
  localparam logic [3:0] TX_LO   = 4'd8;
  localparam logic [3:0] TX_HI   = 4'd9;

  // An address byte is usable only if it selects an implemented entry.
  function automatic logic addr_ok(input logic [7:0] addr_byte, input int depth);
    return int'(addr_byte) < depth;
  endfunction

endpackage

// File: rtl/reg_file_cmd_ctrl_if.sv
// Bundle of the receive, register-file and transmit signals around the
// command controller; master is the controller, slave is its environment.
interface reg_file_cmd_ctrl_if #(
  parameter int DATA_WIDTH = 16,
  parameter int ADDR_WIDTH = 4
);
  logic [7:0]            RX_P_DATA;
  logic                  RX_D_VLD;
  logic [ADDR_WIDTH-1:0] Address;
  logic                  WrEn;
  logic [DATA_WIDTH-1:0] WrData;
  logic                  RdEn;
  logic [DATA_WIDTH-1:0] RdData;
  logic [7:0]            TX_P_DATA;
  logic                  TX_D_VLD;
  logic                  TX_BUSY;
  logic                  CMD_ERR;

  modport master (
    input  RX_P_DATA, RX_D_VLD, RdData, TX_BUSY,
    output Address, WrEn, WrData, RdEn, TX_P_DATA, TX_D_VLD, CMD_ERR
  );

  modport slave (
    output RX_P_DATA, RX_D_VLD, RdData, TX_BUSY,
    input  Address, WrEn, WrData, RdEn, TX_P_DATA, TX_D_VLD, CMD_ERR
  );
endinterface

// File: rtl/reg_file_cmd_ctrl.sv
// Parses 0xAA/0xBB command frames from a byte stream into register-file
// writes and reads, returning read data as two bytes to the transmitter.
module reg_file_cmd_ctrl
  import reg_file_cmd_pkg::*;
#(
  parameter int DATA_WIDTH = 16,
  parameter int ADDR_WIDTH = 4,
  parameter int RF_DEPTH   = RF_DEPTH_DEF
) (
  input  logic                CLK,
  input  logic                RST,
  reg_file_cmd_ctrl_if.master bus
);

  logic [3:0]            state_q,   state_d;
  logic [ADDR_WIDTH-1:0] address_q, address_d;
  logic [DATA_WIDTH-1:0] wr_data_q, wr_data_d;
  logic                  wr_en_q,   wr_en_d;
  logic                  rd_en_q,   rd_en_d;
  logic [7:0]            tx_data_q, tx_data_d;
  logic                  tx_vld_q,  tx_vld_d;
  logic                  cmd_err_q, cmd_err_d;
  logic [15:0]           buf_q,     buf_d;

  logic       rx_vld;
  logic [7:0] rx_byte;
  logic       tx_accept;

  assign rx_vld    = bus.RX_D_VLD;
  assign rx_byte   = bus.RX_P_DATA;
  assign tx_accept = tx_vld_q && !bus.TX_BUSY;

  always_comb begin
    // NOTE: every signal assigned here gets a default first, so no path can leave a latch behind.
    state_d   = state_q;
    address_d = address_q;
    wr_data_d = wr_data_q;
    wr_en_d   = 1'b0;
    rd_en_d   = 1'b0;
    tx_data_d = tx_data_q;
    tx_vld_d  = tx_vld_q;
    cmd_err_d = 1'b0;
    buf_d     = buf_q;

    case (state_q)
      IDLE: begin
        if (rx_vld) begin
          if (rx_byte == CMD_WR)      state_d = WR_ADDR;
          else if (rx_byte == CMD_RD) state_d = RD_ADDR;
          else                        cmd_err_d = 1'b1;
        end
      end

      WR_ADDR, RD_ADDR: begin
        if (rx_vld) begin
          if (addr_ok(rx_byte, RF_DEPTH)) begin
            address_d = rx_byte[ADDR_WIDTH-1:0];
            state_d   = (state_q == WR_ADDR) ? WR_LO : RD_REQ;
            // Strobes are registered, so RdEn is raised on entry to RD_REQ.
            rd_en_d   = (state_q == RD_ADDR);
          end else begin
            cmd_err_d = 1'b1;
            state_d   = IDLE;
          end
        end
      end

      WR_LO: begin
        if (rx_vld) begin
          wr_data_d[7:0] = rx_byte;
          state_d        = WR_HI;
        end
      end

      WR_HI: begin
        if (rx_vld) begin
          wr_data_d[15:8] = rx_byte;
          wr_en_d         = 1'b1;
          state_d         = WR_EXEC;
        end
      end

      WR_EXEC: begin
        cmd_err_d = rx_vld;
        state_d   = IDLE;
      end

      RD_REQ: begin
        cmd_err_d = rx_vld;
        state_d   = RD_CAP;
      end

      // RdData is valid now, one cycle after the RdEn strobe.
      RD_CAP: begin
        cmd_err_d = rx_vld;
        buf_d     = bus.RdData[15:0];
        tx_data_d = bus.RdData[7:0];
        tx_vld_d  = 1'b1;
        state_d   = TX_LO;
      end

      TX_LO: begin
        cmd_err_d = rx_vld;
        if (tx_accept) begin
          tx_data_d = buf_q[15:8];
          state_d   = TX_HI;
        end
      end

      TX_HI: begin
        cmd_err_d = rx_vld;
        if (tx_accept) begin
          tx_vld_d = 1'b0;
          state_d  = IDLE;
        end
      end

      default: state_d = IDLE;
    endcase
  end

  // NOTE: registers update with <= so each flop samples values from before the edge.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_q   <= IDLE;
      address_q <= '0;
      wr_data_q <= '0;
      wr_en_q   <= 1'b0;
      rd_en_q   <= 1'b0;
      tx_data_q <= '0;
      tx_vld_q  <= 1'b0;
      cmd_err_q <= 1'b0;
      buf_q     <= '0;
    end else begin
      state_q   <= state_d;
      address_q <= address_d;
      wr_data_q <= wr_data_d;
      wr_en_q   <= wr_en_d;
      rd_en_q   <= rd_en_d;
      tx_data_q <= tx_data_d;
      tx_vld_q  <= tx_vld_d;
      cmd_err_q <= cmd_err_d;
      buf_q     <= buf_d;
    end
  end

  assign bus.Address   = address_q;
  assign bus.WrEn      = wr_en_q;
  assign bus.WrData    = wr_data_q;
  assign bus.RdEn      = rd_en_q;
  assign bus.TX_P_DATA = tx_data_q;
  assign bus.TX_D_VLD  = tx_vld_q;
  assign bus.CMD_ERR   = cmd_err_q;

endmodule

// File: tb/tb_reg_file_cmd_ctrl.sv
// Scoreboard bench for reg_file_cmd_ctrl: a frame-level reference model queues
// expected writes, reads, transmitted bytes and error pulses; a monitor checks them.
module tb_reg_file_cmd_ctrl;
  import reg_file_cmd_pkg::*;

  localparam int DW    = 16;
  localparam int AW    = 4;
  localparam int DEPTH = RF_DEPTH_DEF;

  logic CLK = 1'b0;
  logic RST = 1'b1;

  reg_file_cmd_ctrl_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus_if ();

  reg_file_cmd_ctrl #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .RF_DEPTH(DEPTH)) dut (
    .CLK (CLK),
    .RST (RST),
    .bus (bus_if.master)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    int addr;
    int data;
    int cyc;
  } exp_t;

  exp_t wr_q[$];
  exp_t rd_q[$];
  exp_t err_q[$];
  exp_t tx_q[$];

  int unsigned n_checks = 0;
  int unsigned n_errors = 0;
  int          cyc      = 0;

  logic [15:0] rf_mem [16] = '{default: 16'h0};
  logic [15:0] ref_rf [DEPTH];
  logic [7:0]  mframe[$];
  bit          rand_busy = 1'b0;

  // Environment register file: writes on WrEn, read data one cycle after RdEn.
  always @(posedge CLK) begin
    cyc <= cyc + 1;
    if (bus_if.WrEn) rf_mem[bus_if.Address] <= bus_if.WrData;
    if (bus_if.RdEn) bus_if.RdData <= rf_mem[bus_if.Address];
  end

  task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
    n_checks++;
    if (actual !== expected) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, actual, expected, cyc);
    end
  endtask

  task automatic unexpected(input string name);
    n_checks++;
    n_errors++;
    $display("FAIL %s: event not expected by model (cycle %0d)", name, cyc);
  endtask

  // Frame-level reference model; called when a byte is presented in cycle cyc,
  // so any strobe or error it causes is visible in cycle cyc+1.
  task automatic model_rx(input logic [7:0] b, input bit drop);
    exp_t e;
    e = '{addr: 0, data: 0, cyc: cyc + 1};
    if (drop) begin
      err_q.push_back(e);
    end else if (mframe.size() == 0) begin
      if (b == CMD_WR || b == CMD_RD) mframe.push_back(b);
      else err_q.push_back(e);
    end else if (mframe.size() == 1) begin
      if (int'(b) >= DEPTH) begin
        err_q.push_back(e);
        mframe.delete();
      end else if (mframe[0] == CMD_RD) begin
        e.addr = int'(b);
        rd_q.push_back(e);
        tx_q.push_back('{addr: 0, data: int'(ref_rf[b][7:0]), cyc: 0});
        tx_q.push_back('{addr: 0, data: int'(ref_rf[b][15:8]), cyc: 0});
        mframe.delete();
      end else begin
        mframe.push_back(b);
      end
    end else if (mframe.size() == 2) begin
      mframe.push_back(b);
    end else begin
      e.addr = int'(mframe[1]);
      e.data = int'(b) * 256 + int'(mframe[2]);
      wr_q.push_back(e);
      ref_rf[mframe[1]] = 16'(e.data);
      mframe.delete();
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
    if (rand_busy) bus_if.TX_BUSY = ($urandom_range(0, 99) < 40);
  endtask

  task automatic send_byte(input logic [7:0] b, input bit drop = 1'b0);
    bus_if.RX_P_DATA = b;
    bus_if.RX_D_VLD  = 1'b1;
    model_rx(b, drop);
    tick();
    bus_if.RX_D_VLD  = 1'b0;
  endtask

  function automatic bit pending();
    return (wr_q.size() + rd_q.size() + err_q.size() + tx_q.size()) != 0;
  endfunction

  task automatic drain(input int budget);
    int n = 0;
    while (pending() && n < budget) begin
      tick();
      n++;
    end
    if (pending()) begin
      unexpected("drain_timeout");
      wr_q.delete(); rd_q.delete(); err_q.delete(); tx_q.delete();
    end
    tick();
  endtask

  task automatic check_outputs_zero(input string tag);
    check({tag, "_addr"},  32'(bus_if.Address),   0);
    check({tag, "_wdata"}, 32'(bus_if.WrData),    0);
    check({tag, "_wren"},  32'(bus_if.WrEn),      0);
    check({tag, "_rden"},  32'(bus_if.RdEn),      0);
    check({tag, "_txd"},   32'(bus_if.TX_P_DATA), 0);
    check({tag, "_txv"},   32'(bus_if.TX_D_VLD),  0);
    check({tag, "_err"},   32'(bus_if.CMD_ERR),   0);
  endtask

  // Monitor: pops the matching expectation whenever the DUT shows an event.
  exp_t       mon_e;
  logic       prev_stall = 1'b0;
  logic [7:0] prev_tx    = 8'h0;

  always @(negedge CLK) begin
    if (RST) begin
      if (bus_if.WrEn && bus_if.RdEn) unexpected("wren_rden_overlap");
      if (bus_if.WrEn) begin
        if (wr_q.size() == 0) unexpected("wren");
        else begin
          mon_e = wr_q.pop_front();
          check("wr_addr",  32'(bus_if.Address), mon_e.addr);
          check("wr_data",  32'(bus_if.WrData),  mon_e.data);
          check("wr_cycle", cyc,                 mon_e.cyc);
        end
      end
      if (bus_if.RdEn) begin
        if (rd_q.size() == 0) unexpected("rden");
        else begin
          mon_e = rd_q.pop_front();
          check("rd_addr",  32'(bus_if.Address), mon_e.addr);
          check("rd_cycle", cyc,                 mon_e.cyc);
        end
      end
      if (bus_if.CMD_ERR) begin
        if (err_q.size() == 0) unexpected("cmd_err");
        else begin
          mon_e = err_q.pop_front();
          check("err_cycle", cyc, mon_e.cyc);
        end
      end
      if (prev_stall) begin
        check("tx_vld_held",  32'(bus_if.TX_D_VLD),  1);
        check("tx_data_hold", 32'(bus_if.TX_P_DATA), 32'(prev_tx));
      end
      if (bus_if.TX_D_VLD && !bus_if.TX_BUSY) begin
        if (tx_q.size() == 0) unexpected("tx_byte");
        else begin
          mon_e = tx_q.pop_front();
          check("tx_data", 32'(bus_if.TX_P_DATA), mon_e.data);
        end
      end
      prev_stall = bus_if.TX_D_VLD && bus_if.TX_BUSY;
      prev_tx    = bus_if.TX_P_DATA;
    end else begin
      prev_stall = 1'b0;
    end
  end

  initial begin
    #500_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] a;
    logic [7:0] b;
    int         kind;

    foreach (ref_rf[i]) ref_rf[i] = 16'h0;
    bus_if.RX_P_DATA = 8'h0;
    bus_if.RX_D_VLD  = 1'b0;
    bus_if.TX_BUSY   = 1'b0;

    // Asynchronous reset, checked before any clock edge occurs.
    #2 RST = 1'b0;
    #1 check_outputs_zero("reset");
    repeat (3) tick();
    RST = 1'b1;
    tick();

    // Basic write, then read-back with the transmitter idle.
    send_byte(CMD_WR); send_byte(8'h03); send_byte(8'h34); send_byte(8'h12);
    drain(50);
    send_byte(CMD_RD); send_byte(8'h03);
    drain(50);

    // Illegal command byte, then out-of-range write address.
    send_byte(8'h55);
    drain(20);
    send_byte(CMD_WR); send_byte(8'h09);
    drain(20);

    // Read with the transmitter busy: low byte held, then a byte dropped during the high-byte stall.
    bus_if.TX_BUSY = 1'b1;
    send_byte(CMD_RD); send_byte(8'h03);
    repeat (20) tick();
    check("stall_lo_vld",  32'(bus_if.TX_D_VLD),  1);
    check("stall_lo_data", 32'(bus_if.TX_P_DATA), 32'h34);
    bus_if.TX_BUSY = 1'b0;
    tick();
    bus_if.TX_BUSY = 1'b1;
    tick();
    send_byte(8'h77, 1'b1);
    repeat (5) tick();
    check("stall_hi_data", 32'(bus_if.TX_P_DATA), 32'h12);
    bus_if.TX_BUSY = 1'b0;
    drain(50);

    // Byte arriving while the write strobe is out is dropped; the write still happens.
    send_byte(CMD_WR); send_byte(8'h05); send_byte(8'h11); send_byte(8'h22);
    send_byte(8'h99, 1'b1);
    drain(50);

    // Reset mid-frame discards the partial write.
    send_byte(CMD_WR); send_byte(8'h03); send_byte(8'h34);
    #2 RST = 1'b0;
    #1 check_outputs_zero("midreset");
    mframe.delete();
    repeat (2) tick();
    RST = 1'b1;
    tick();
    send_byte(CMD_WR); send_byte(8'h02); send_byte(8'hCD); send_byte(8'hAB);
    drain(50);
    send_byte(CMD_RD); send_byte(8'h02);
    drain(50);

    // Randomized frames with random transmitter back-pressure.
    rand_busy = 1'b1;
    for (int f = 0; f < 80; f++) begin
      kind = int'($urandom_range(0, 9));
      if (kind <= 7 || kind == 9) begin
        a = (kind == 9) ? 8'($urandom_range(DEPTH, 255)) : 8'($urandom_range(0, DEPTH - 1));
        send_byte(kind[0] ? CMD_RD : CMD_WR);
        repeat ($urandom_range(0, 2)) tick();
        send_byte(a);
        if (kind != 9 && !kind[0]) begin
          repeat ($urandom_range(0, 2)) tick();
          send_byte(8'($urandom));
          repeat ($urandom_range(0, 2)) tick();
          send_byte(8'($urandom));
        end
      end else begin
        b = 8'($urandom);
        if (b == CMD_WR || b == CMD_RD) b = 8'h00;
        send_byte(b);
      end
      drain(500);
    end
    rand_busy = 1'b0;
    bus_if.TX_BUSY = 1'b0;
    drain(100);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
